// File: rtl/griffin_sponge_if.sv
// Bundle between the Griffin sponge front end, its message source,
// digest sink and the permutation core.
interface griffin_sponge_if #(
    parameter int N_BITS     = 254,
    parameter int STATE_SIZE = 3
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [N_BITS-1:0]                    in_data;
    logic                                 in_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [N_BITS-1:0]                    out_data;
    logic                                 perm_start;
    logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_out;
    logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_in;
    logic                                 perm_done;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        input  perm_state_in, perm_done,
        output in_ready, out_valid, out_data,
        output perm_start, perm_state_out
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        output perm_state_in, perm_done,
        input  in_ready, out_valid, out_data,
        input  perm_start, perm_state_out
    );
endinterface

// File: rtl/griffin_sponge.sv
// Sponge front end for the Griffin permutation: absorbs field elements,
// applies 10* padding, runs one permutation per block and squeezes st[0].
module griffin_sponge #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                RATE          = 2,
    parameter int                CAPACITY      = 1
) (
    input logic              clk,
    input logic              reset,
    griffin_sponge_if.master bus
);
    localparam int STATE_SIZE = RATE + CAPACITY;
    localparam int IW         = $clog2(STATE_SIZE);

    typedef enum logic [2:0] {
        ABSORB,
        PAD,
        PERM_START,
        PERM_WAIT,
        SQUEEZE
    } state_t;

    state_t                            state;
    logic [STATE_SIZE-1:0][N_BITS-1:0] st;
    logic [IW-1:0]                     idx;
    logic [IW-1:0]                     pad_pos;
    logic                              pad_pending;
    logic                              last_msg;
    logic                              out_valid_q;
    logic                              perm_start_q;

    function automatic logic [N_BITS-1:0] add_mod(
        input logic [N_BITS-1:0] a,
        input logic [N_BITS-1:0] b
    );
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME_MODULUS})
            s = s - {1'b0, PRIME_MODULUS};
        return s[N_BITS-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ABSORB;
            st           <= '0;
            idx          <= '0;
            pad_pos      <= '0;
            pad_pending  <= 1'b0;
            last_msg     <= 1'b0;
            out_valid_q  <= 1'b0;
            perm_start_q <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            unique case (state)
                ABSORB: begin
                    if (bus.in_valid) begin
                        st[idx] <= add_mod(st[idx], bus.in_data);
                        if (idx == IW'(RATE - 1)) begin
                            idx          <= '0;
                            pad_pending  <= bus.in_last;
                            last_msg     <= bus.in_last;
                            perm_start_q <= 1'b1;
                            state        <= PERM_START;
                        end else if (bus.in_last) begin
                            pad_pos  <= idx + 1'b1;
                            last_msg <= 1'b1;
                            state    <= PAD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PAD: begin
                    st[pad_pos]  <= add_mod(st[pad_pos], N_BITS'(1));
                    pad_pending  <= 1'b0;
                    perm_start_q <= 1'b1;
                    state        <= PERM_START;
                end
                PERM_START: begin
                    state <= PERM_WAIT;
                end
                PERM_WAIT: begin
                    if (bus.perm_done) begin
                        st <= bus.perm_state_in;
                        // A full final block still owes a padding-only block
                        if (pad_pending) begin
                            pad_pos <= '0;
                            state   <= PAD;
                        end else if (last_msg) begin
                            out_valid_q <= 1'b1;
                            state       <= SQUEEZE;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                SQUEEZE: begin
                    if (bus.out_ready) begin
                        st          <= '0;
                        idx         <= '0;
                        last_msg    <= 1'b0;
                        out_valid_q <= 1'b0;
                        state       <= ABSORB;
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end

    assign bus.in_ready       = (state == ABSORB);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = st[0];
    assign bus.perm_start     = perm_start_q;
    assign bus.perm_state_out = st;
endmodule

// File: tb/tb_griffin_sponge.sv
// Randomized bench for griffin_sponge with a permutation core stub and a
// message-level sponge reference model.
module tb_griffin_sponge;
    typedef logic [255:0]       w_t;
    typedef logic [2:0][255:0]  st_t;

    localparam w_t P =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;

    griffin_sponge_if #(.N_BITS(254), .STATE_SIZE(3)) bus ();

    griffin_sponge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int  stub_mode = 0;
    int  stub_dly  = 5;
    st_t started[$];
    st_t exp_blk[$];
    w_t  exp_dig;

    task automatic chk(input string tag, input w_t got, input w_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic st_t perm_fn(input st_t s, input int mode);
        st_t r;
        r = s;
        if (mode == 1) begin
            r[0] = P - 1;
            r[1] = P - 2;
            r[2] = '0;
        end else if (mode == 2) begin
            r[0] = (s[0] + s[1] + s[2]) % P;
            r[1] = (s[0] + s[0] + s[2] + 3) % P;
            r[2] = (s[1] + s[2] + 11) % P;
        end
        return r;
    endfunction

    function automatic w_t rand_elem();
        w_t w;
        for (int i = 0; i < 8; i++)
            w[i*32 +: 32] = $urandom;
        return w % P;
    endfunction

    // Permutation core stub: captures the state at each start pulse.
    initial begin
        st_t cap;
        st_t res;
        bus.perm_done     = 1'b0;
        bus.perm_state_in = '0;
        forever begin
            @(negedge clk);
            if (bus.perm_start) begin
                for (int j = 0; j < 3; j++)
                    cap[j] = {2'b00, bus.perm_state_out[j]};
                started.push_back(cap);
                res = perm_fn(cap, stub_mode);
                repeat (stub_dly - 1) @(negedge clk);
                for (int j = 0; j < 3; j++)
                    bus.perm_state_in[j] = res[j][253:0];
                bus.perm_done = 1'b1;
                @(negedge clk);
                bus.perm_done = 1'b0;
            end
        end
    end

    // Sponge reference: pad with 1 then zeros up to a RATE multiple.
    task automatic ref_msg(input w_t m[$]);
        w_t  pm[$];
        st_t s;
        pm = m;
        pm.push_back(1);
        while (pm.size() % 2 != 0)
            pm.push_back(0);
        s = '0;
        exp_blk.delete();
        for (int b = 0; b < pm.size(); b += 2) begin
            s[0] = (s[0] + pm[b]) % P;
            s[1] = (s[1] + pm[b+1]) % P;
            exp_blk.push_back(s);
            s = perm_fn(s, stub_mode);
        end
        exp_dig = s[0];
    endtask

    task automatic send(input string tag, input w_t m[$]);
        int cnt;
        for (int i = 0; i < m.size(); i++) begin
            if ($urandom_range(0, 3) == 0)
                @(negedge clk);
            cnt = 0;
            while (!bus.in_ready && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 300) begin
                chk({tag, ".in_tmo"}, 0, 1);
                return;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = m[i][253:0];
            bus.in_last  = (i == m.size() - 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic get_digest(input string tag, input int hold);
        int cnt;
        cnt = 0;
        while (!bus.out_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 400) begin
            chk({tag, ".out_tmo"}, 0, 1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            chk({tag, ".hold_v"}, w_t'(bus.out_valid), 1);
            chk({tag, ".hold_d"}, w_t'(bus.out_data), exp_dig);
            chk({tag, ".hold_rdy"}, w_t'(bus.in_ready), 0);
            @(negedge clk);
        end
        chk({tag, ".dig"}, w_t'(bus.out_data), exp_dig);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".v_clr"}, w_t'(bus.out_valid), 0);
        chk({tag, ".rdy_back"}, w_t'(bus.in_ready), 1);
    endtask

    task automatic run_msg(input string tag, input w_t m[$], input int hold);
        started.delete();
        ref_msg(m);
        send(tag, m);
        get_digest(tag, hold);
        chk({tag, ".nblk"}, w_t'(started.size()), w_t'(exp_blk.size()));
        for (int b = 0; b < exp_blk.size() && b < started.size(); b++)
            for (int j = 0; j < 3; j++)
                chk($sformatf("%s.blk%0d.s%0d", tag, b, j),
                    started[b][j], exp_blk[b][j]);
    endtask

    initial begin
        w_t m[$];
        int cnt;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", w_t'(bus.out_valid), 0);
        chk("rst.perm_start", w_t'(bus.perm_start), 0);
        chk("rst.in_ready", w_t'(bus.in_ready), 1);
        chk("rst.st", w_t'(bus.perm_state_out[0] | bus.perm_state_out[1]
                          | bus.perm_state_out[2]), 0);

        stub_mode = 0;
        stub_dly  = 5;
        m = '{};
        m.push_back(5);
        run_msg("one", m, 0);

        m = '{};
        m.push_back(7);
        m.push_back(9);
        run_msg("full", m, 1);

        stub_mode = 1;
        m = '{};
        m.push_back(0);
        m.push_back(0);
        m.push_back(5);
        run_msg("wrap", m, 0);

        stub_mode = 2;
        stub_dly  = 3;
        m = '{};
        m.push_back(rand_elem());
        m.push_back(rand_elem());
        m.push_back(rand_elem());
        run_msg("bp", m, 10);
        for (int j = 0; j < 3; j++)
            chk($sformatf("bp.st_clr%0d", j),
                w_t'(bus.perm_state_out[j]), 0);

        // Reset while the core is busy; its late done arrives as a stray.
        stub_mode = 0;
        stub_dly  = 20;
        started.delete();
        m = '{};
        m.push_back(11);
        send("rmid", m);
        cnt = 0;
        while (started.size() == 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("rmid.start", w_t'(cnt < 50), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid || bus.perm_start)
                seen = 1'b1;
        end
        chk("rmid.quiet", w_t'(seen), 0);
        chk("rmid.nstart", w_t'(started.size()), 1);
        stub_dly = 5;
        m = '{};
        m.push_back(3);
        run_msg("after_rst", m, 0);

        stub_mode = 2;
        for (int t = 0; t < 20; t++) begin
            stub_dly = $urandom_range(2, 7);
            m = '{};
            for (int k = 0; k < $urandom_range(1, 7); k++)
                m.push_back(rand_elem());
            run_msg($sformatf("rnd%0d", t), m, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
